// File: rtl/irq_pkg.sv
// Shared constants for the memory-mapped interrupt controller and interval timer.
package irq_pkg;

    localparam int unsigned OFF_W       = 4;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned CTRL_W      = 2;
    localparam int unsigned CTRL_TEN    = 0;
    localparam int unsigned CTRL_GIE    = 1;
    localparam int unsigned CAUSE_VALID = 31;
    localparam int unsigned CAUSE_IDX_W = 5;

    localparam logic [OFF_W-1:0] OFF_PENDING = 4'h0;
    localparam logic [OFF_W-1:0] OFF_MASK    = 4'h1;
    localparam logic [OFF_W-1:0] OFF_CAUSE   = 4'h2;
    localparam logic [OFF_W-1:0] OFF_TLOAD   = 4'h3;
    localparam logic [OFF_W-1:0] OFF_TCOUNT  = 4'h4;
    localparam logic [OFF_W-1:0] OFF_CTRL    = 4'h5;

endpackage

// File: rtl/irq_timer.sv
// Interval down-counter: reloads from TLOAD on reaching zero and flags a one-cycle tick.
module irq_timer
    import irq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              start,
    input  logic              load_we,
    input  logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] tload,
    output logic [DATA_W-1:0] tcount,
    output logic              tick
);

    // Tick is combinational so pending[0] sets on the same edge TCOUNT reloads.
    always_comb begin
        tick = en && (tload != '0) && (tcount == '0) && !load_we && !start;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tload  <= '0;
            tcount <= '0;
        end else if (load_we) begin
            tload  <= load_data;
            tcount <= load_data;
        end else if (start) begin
            tcount <= tload;
        end else if (en && (tload != '0)) begin
            if (tcount == '0) begin
                tcount <= tload;
            end else begin
                tcount <= tcount - DATA_W'(1);
            end
        end
    end

endmodule

// File: rtl/irq_ctl.sv
// Interrupt controller top: window decode, edge capture into PENDING, masking, cause encode and irq flop.
module irq_ctl
    import irq_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned NSRC      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NSRC-1:0]   src,
    input  logic [31:0]       memAddr,
    input  logic [31:0]       memWriteData,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       memReadData,
    output logic              hit,
    output logic              irq
);

    localparam int unsigned PW = NSRC + 1;

    logic [PW-1:0]          pending;
    logic [PW-1:0]          mask;
    logic [NSRC-1:0]        prev;
    logic [CTRL_W-1:0]      ctrl;
    logic [OFF_W-1:0]       off;
    logic                   we;
    logic                   start;
    logic                   tick;
    logic [PW-1:0]          w1c;
    logic [PW-1:0]          set_vec;
    logic [PW-1:0]          active;
    logic [CAUSE_IDX_W-1:0] cause_idx;
    logic [DATA_W-1:0]      cause;
    logic [DATA_W-1:0]      tload;
    logic [DATA_W-1:0]      tcount;
    logic                   unused_addr;

    assign unused_addr = ^memAddr[1:0];

    always_comb begin
        hit     = (memAddr[31:6] == BASE_ADDR[31:6]);
        off     = memAddr[5:2];
        we      = MemWrite && hit;
        start   = we && (off == OFF_CTRL) && memWriteData[CTRL_TEN] && !ctrl[CTRL_TEN];
        w1c     = (we && (off == OFF_PENDING)) ? memWriteData[PW-1:0] : '0;
        set_vec = {src & ~prev, tick};
        active  = pending & mask;
    end

    irq_timer u_timer (
        .clk       (clk),
        .reset     (reset),
        .en        (ctrl[CTRL_TEN]),
        .start     (start),
        .load_we   (we && (off == OFF_TLOAD)),
        .load_data (memWriteData),
        .tload     (tload),
        .tcount    (tcount),
        .tick      (tick)
    );

    // Lowest active index wins; scan from the top so the last hit is the lowest.
    always_comb begin
        cause_idx = '0;
        for (int i = PW - 1; i >= 0; i--) begin
            if (active[i]) begin
                cause_idx = CAUSE_IDX_W'(i);
            end
        end
        cause                        = '0;
        cause[CAUSE_VALID]           = |active;
        cause[CAUSE_IDX_W-1:0]       = cause_idx;
    end

    always_comb begin
        memReadData = '0;
        if (MemRead && hit) begin
            case (off)
                OFF_PENDING: memReadData = DATA_W'(pending);
                OFF_MASK:    memReadData = DATA_W'(mask);
                OFF_CAUSE:   memReadData = cause;
                OFF_TLOAD:   memReadData = tload;
                OFF_TCOUNT:  memReadData = tcount;
                OFF_CTRL:    memReadData = DATA_W'(ctrl);
                default:     memReadData = '0;
            endcase
        end
    end

    // prev tracks src even in reset so levels held through reset raise nothing.
    always_ff @(posedge clk) begin
        prev <= src;
        if (reset) begin
            pending <= '0;
            mask    <= '0;
            ctrl    <= '0;
            irq     <= 1'b0;
        end else begin
            pending <= (pending & ~w1c) | set_vec;
            irq     <= ctrl[CTRL_GIE] && (|active);
            if (we && (off == OFF_MASK)) begin
                mask <= memWriteData[PW-1:0];
            end
            if (we && (off == OFF_CTRL)) begin
                ctrl <= memWriteData[CTRL_W-1:0];
            end
        end
    end

endmodule

// File: doc/irq_ctl.md
# irq_ctl

Memory-mapped interrupt controller and interval timer on the processor's data-memory port. It decodes the processor's data address, write-data and read/write strobes, latches rising edges from external device request lines and an internal down-counter into a pending register, and drives the processor's `irq` input. Software masks, identifies and clears sources through word registers in a 64-byte window.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000: window base; bits [5:0] must be 0.
- `NSRC`, 8: external request lines, 1..15. Pending/mask width is NSRC+1.
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `src`  in  NSRC  device request levels, synchronous to `clk`.
- `memAddr`  in  32  processor data address.
- `memWriteData`  in  32  processor store data.
- `MemRead`  in  1  load strobe.
- `MemWrite`  in  1  store strobe.
- `memReadData`  out  32  register read data; 0 when not hit.
- `hit`  out  1  `memAddr[31:6] == BASE_ADDR[31:6]`; steers the system load mux.
- `irq`  out  1  registered interrupt request.

## Operation
- Registers (offset, `memAddr[5:2]` decode, `memAddr[1:0]` ignored):
  - 0x00 PENDING: R; W1C. Bit 0 = timer, bit i+1 = `src[i]`.
  - 0x04 MASK: RW, 1 = enabled.
  - 0x08 CAUSE: R. Bit 31 = any pending&mask; [4:0] = lowest set index of pending&mask; 0 if none.
  - 0x0C TLOAD: RW 32-bit reload value; a write also loads TCOUNT.
  - 0x10 TCOUNT: R.
  - 0x14 CTRL: RW. Bit 0 = timer enable, bit 1 = global irq enable.
  - Other offsets read 0; writes ignored. Bits above implemented width read 0.
- Edge detect: `prev` register holds last `src`; pending[i+1] sets when `src[i] & ~prev[i]`. During reset `prev <= src`, so a level held through reset raises nothing.
- Set beats clear: W1C of a bit in the same cycle its set condition fires leaves it 1.
- Timer: when CTRL[0]=1 and TLOAD≠0, TCOUNT decrements each cycle; at TCOUNT==0 it reloads TLOAD and sets pending[0] (period = TLOAD+1 cycles). CTRL[0] 0→1 loads TCOUNT from TLOAD. TLOAD==0 or CTRL[0]=0: TCOUNT holds, no ticks.
- `irq` next = CTRL[1] & |(PENDING & MASK).
- Writes act only when `MemWrite & hit`; reads are combinational when `MemRead & hit`. Simultaneous read and write to one register returns pre-write value.

## Timing
- Reset values: PENDING, MASK, CTRL, TLOAD, TCOUNT = 0; `irq` = 0. `memReadData`/`hit` are combinational from inputs.
- `src[i]` first sampled high at edge k → PENDING bit visible after k → `irq` high after edge k+1.
- W1C store at edge m → bit clear after m → `irq` low after m+1 if nothing else pending.
- MASK/CTRL writes affect `irq` one edge after taking effect.
- Timer fire at edge t (TCOUNT was 0) → pending[0] after t, `irq` after t+1; TCOUNT = TLOAD after t.
- Reset mid-count or mid-pending: all state returns to reset values next edge; reset wins over any simultaneous store.

## Structure
- Package `irq_pkg`: register offset constants, CTRL bit positions, CAUSE valid-bit position.
- Sub-module `irq_timer`: TLOAD/TCOUNT/enable logic, outputs a one-cycle `tick`.
- Top: address decode, edge detect, pending/mask, priority encoder, read mux, `irq` flop.

## Test plan
- Reset with `src[2]`=1 held, release → PENDING reads 0, `irq`=0 for 10 cycles.
- MASK=0x1FF, CTRL=0x2, pulse `src[3]` one cycle → PENDING=0x10, CAUSE=0x8000_0004, `irq` high 2 edges after pulse; store 0x10 to PENDING → `irq` low 2 edges later.
- `src[0]` and `src[5]` rise together, MASK=0x40 → CAUSE=0x8000_0006; MASK=0x1FF → CAUSE=0x8000_0001.
- TLOAD=4, CTRL=0x3, MASK=0x1 → pending[0] sets every 5 cycles; W1C on a tick cycle leaves bit 1.
- TLOAD=0, CTRL=0x1 → TCOUNT stays 0, no ticks for 50 cycles.
- Store/load at BASE_ADDR+0x40 → `hit`=0, `memReadData`=0, no register changes; load at +0x18 inside window → 0.
